rx_control_module: RTL and testbench

- Receive-side controller for the serial test link; the counterpart of the periodic incrementing-byte transmit controller.
- Enables the UART receiver and captures each byte on the receiver's done strobe.
- Checks that received bytes follow the +1 incrementing sequence (wrapping 8'hFF -> 8'h00) and counts sequence errors.
- Runs a silence watchdog and exposes status for LEDs/debug.

---
 rtl/rx_control_module_if.sv | 23 ++
 rtl/rx_control_module.sv | 91 +++++++++
 tb/tb_rx_control_module.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_control_module_if.sv
// Receiver-side link bundle: UART receiver strobe/data in, enable and status out.
// master = UART receiver side (drives done/data), slave = rx_control_module.
interface rx_control_module_if;
  logic       RX_Done_Sig;
  logic [7:0] RX_Data;
  logic       RX_En_Sig;
  logic [7:0] Rx_Byte;
  logic       Byte_Valid;
  logic       Seq_Err;
  logic [7:0] Err_Count;
  logic       Locked;
  logic       Timeout;

  modport master (
    output RX_Done_Sig, RX_Data,
    input  RX_En_Sig, Rx_Byte, Byte_Valid, Seq_Err, Err_Count, Locked, Timeout
  );

  modport slave (
    input  RX_Done_Sig, RX_Data,
    output RX_En_Sig, Rx_Byte, Byte_Valid, Seq_Err, Err_Count, Locked, Timeout
  );
endinterface

// File: rtl/rx_control_module.sv
// Receive controller for the serial test link: captures bytes, checks the +1
// incrementing sequence, counts mismatches and runs a silence watchdog.
module rx_control_module #(
  parameter logic [24:0] T_TIMEOUT = 25'd11_999_999
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  rx_control_module_if.slave   rx
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        bv_q, bv_d;
  logic        se_q, se_d;
  logic [7:0]  err_q, err_d;
  logic        locked_q, locked_d;
  logic [7:0]  exp_q, exp_d;
  logic [24:0] wd_q, wd_d;
  logic        en, timeout;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      rx_byte_q <= 8'h00;
      bv_q     <= 1'b0;
      se_q     <= 1'b0;
      err_q    <= 8'h00;
      locked_q <= 1'b0;
      exp_q    <= 8'h00;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      rx_byte_q <= rx_byte_d;
      bv_q     <= bv_d;
      se_q     <= se_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      exp_q    <= exp_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rx_byte_d = rx_byte_q;
    bv_d      = 1'b0;
    se_d      = 1'b0;
    err_d     = err_q;
    locked_d  = locked_q;
    exp_d     = exp_q;
    wd_d      = '0;
    en        = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_WAIT;
      S_WAIT: begin
        en = 1'b1;
        // A capture on the watchdog's terminal cycle takes priority over the timeout.
        if (rx.RX_Done_Sig) begin
          state_d   = S_GAP;
          rx_byte_d = rx.RX_Data;
          bv_d      = 1'b1;
          locked_d  = 1'b1;
          exp_d     = rx.RX_Data + 8'd1;
          if (locked_q && (rx.RX_Data != exp_q)) begin
            se_d = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end
        end else if (wd_q == T_TIMEOUT - 25'd1) begin
          timeout  = 1'b1;
          locked_d = 1'b0;
        end else begin
          wd_d = wd_q + 25'd1;
        end
      end
      S_GAP:   state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  assign rx.RX_En_Sig  = en;
  assign rx.Rx_Byte    = rx_byte_q;
  assign rx.Byte_Valid = bv_q;
  assign rx.Seq_Err    = se_q;
  assign rx.Err_Count  = err_q;
  assign rx.Locked     = locked_q;
  assign rx.Timeout    = timeout;

endmodule

// File: tb/tb_rx_control_module.sv
// Bench for rx_control_module: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the receive rules.
module tb_rx_control_module;
  localparam int T = 100;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  rx_control_module_if ifc();

  rx_control_module #(.T_TIMEOUT(25'd100)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .rx   (ifc)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int bv_seen = 0;
  int se_seen = 0;

  // Model: receiver enabled except for one cycle after reset and after each capture.
  bit         m_en;
  int         m_silent;
  bit         m_locked;
  logic [7:0] m_exp, m_byte, m_cnt;
  bit         m_bv, m_se;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_en = 0; m_silent = 0; m_locked = 0; m_exp = 8'h00;
      m_byte = 8'h00; m_cnt = 8'h00; m_bv = 0; m_se = 0;
    end else begin
      m_bv = 0;
      m_se = 0;
      if (!m_en) begin
        m_en = 1;
        m_silent = 0;
      end else if (ifc.RX_Done_Sig) begin
        m_byte = ifc.RX_Data;
        m_bv = 1;
        if (m_locked && ifc.RX_Data != m_exp) begin
          m_se = 1;
          if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
        end
        m_locked = 1;
        m_exp = 8'((int'(ifc.RX_Data) + 1) % 256);
        m_en = 0;
        m_silent = 0;
      end else if (m_silent == T - 1) begin
        m_locked = 0;
        m_silent = 0;
      end else begin
        m_silent++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("RX_En_Sig",  32'(ifc.RX_En_Sig), 32'(m_en));
    chk("Rx_Byte",    32'(ifc.Rx_Byte), 32'(m_byte));
    chk("Byte_Valid", 32'(ifc.Byte_Valid), 32'(m_bv));
    chk("Seq_Err",    32'(ifc.Seq_Err), 32'(m_se));
    chk("Err_Count",  32'(ifc.Err_Count), 32'(m_cnt));
    chk("Locked",     32'(ifc.Locked), 32'(m_locked));
    chk("Timeout",    32'(ifc.Timeout),
        32'(m_en && (m_silent == T - 1) && !ifc.RX_Done_Sig));
    if (ifc.Byte_Valid === 1'b1) bv_seen++;
    if (ifc.Seq_Err === 1'b1) se_seen++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (ifc.RX_En_Sig !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("send_enable_wait", 32'(ifc.RX_En_Sig), 32'd1);
    ifc.RX_Done_Sig = 1'b1;
    ifc.RX_Data = b;
    tick();
    ifc.RX_Done_Sig = 1'b0;
    ifc.RX_Data = 8'($urandom);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"},  32'(ifc.RX_En_Sig), 32'd0);
    chk({tag, "_byte"}, 32'(ifc.Rx_Byte), 32'h00);
    chk({tag, "_bv"},  32'(ifc.Byte_Valid), 32'd0);
    chk({tag, "_se"},  32'(ifc.Seq_Err), 32'd0);
    chk({tag, "_cnt"}, 32'(ifc.Err_Count), 32'h00);
    chk({tag, "_lock"}, 32'(ifc.Locked), 32'd0);
    chk({tag, "_to"},  32'(ifc.Timeout), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int se0, bv0, j;
    logic [7:0] seq;
    ifc.RX_Done_Sig = 1'b0;
    ifc.RX_Data = 8'h00;
    #12;
    chk_reset_vals("reset");
    RSTn = 1'b1;
    tick();

    // Incrementing stream from a seed
    send(8'h32); send(8'h33); send(8'h34);
    tick(); tick();
    @(negedge CLK);
    chk("t1_byte", 32'(ifc.Rx_Byte), 32'h34);
    chk("t1_lock", 32'(ifc.Locked), 32'd1);
    chk("t1_cnt", 32'(ifc.Err_Count), 32'h00);
    chk("t1_se", 32'(se_seen), 32'd0);
    chk("t1_bv", 32'(bv_seen), 32'd3);

    // One mismatch, then resync
    se0 = se_seen;
    send(8'h40); send(8'h41);
    tick(); tick();
    @(negedge CLK);
    chk("t2_cnt", 32'(ifc.Err_Count), 32'h01);
    chk("t2_se", 32'(se_seen - se0), 32'd1);

    // Silence watchdog: pulse on the 100th WAIT cycle after the gap
    send(8'h42);
    j = 0;
    while (j < 200) begin
      @(negedge CLK);
      j++;
      if (ifc.Timeout === 1'b1) break;
    end
    chk("t3_timeout_cycle", 32'(j), 32'd101);
    @(negedge CLK);
    chk("t3_unlock", 32'(ifc.Locked), 32'd0);
    chk("t3_cnt", 32'(ifc.Err_Count), 32'h01);
    tick();

    // Seed after timeout
    se0 = se_seen;
    send(8'h10);
    @(negedge CLK);
    chk("t4_se", 32'(se_seen - se0), 32'd0);
    chk("t4_lock", 32'(ifc.Locked), 32'd1);
    chk("t4_cnt", 32'(ifc.Err_Count), 32'h01);

    // Capture on the watchdog terminal cycle
    tick();
    repeat (T - 1) tick();
    ifc.RX_Done_Sig = 1'b1;
    ifc.RX_Data = 8'h11;
    @(negedge CLK);
    chk("t5_no_timeout", 32'(ifc.Timeout), 32'd0);
    tick();
    ifc.RX_Done_Sig = 1'b0;
    @(negedge CLK);
    chk("t5_bv", 32'(ifc.Byte_Valid), 32'd1);
    chk("t5_lock", 32'(ifc.Locked), 32'd1);
    tick();

    // Done strobe during GAP is ignored
    bv0 = bv_seen;
    send(8'h12);
    ifc.RX_Done_Sig = 1'b1;
    ifc.RX_Data = 8'h55;
    tick();
    ifc.RX_Done_Sig = 1'b0;
    tick(); tick();
    @(negedge CLK);
    chk("t6_bv", 32'(bv_seen - bv0), 32'd1);
    chk("t6_byte", 32'(ifc.Rx_Byte), 32'h12);
    tick();

    // Asynchronous reset mid-stream, then seed and wrap
    send(8'h13);
    @(posedge CLK);
    #3;
    RSTn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick(); tick();
    RSTn = 1'b1;
    se0 = se_seen;
    send(8'hFE); send(8'hFF); send(8'h00);
    tick();
    @(negedge CLK);
    chk("t7_se", 32'(se_seen - se0), 32'd0);
    chk("t7_byte", 32'(ifc.Rx_Byte), 32'h00);
    chk("t7_cnt", 32'(ifc.Err_Count), 32'h00);
    chk("t7_lock", 32'(ifc.Locked), 32'd1);
    tick();

    // Saturation
    se0 = se_seen;
    repeat (300) send(8'hAA);
    tick();
    @(negedge CLK);
    chk("t8_cnt", 32'(ifc.Err_Count), 32'hFF);
    chk("t8_se", 32'(se_seen - se0), 32'd300);

    // Random traffic; reset first so the counter is live again
    @(posedge CLK);
    #3;
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    seq = 8'($urandom);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        ifc.RX_Done_Sig = 1'b0;
        repeat (T + 20) tick();
      end else begin
        ifc.RX_Done_Sig = ($urandom_range(0, 2) == 0);
        ifc.RX_Data = ($urandom_range(0, 5) == 0) ? 8'($urandom) : seq;
        if (ifc.RX_Done_Sig && ifc.RX_En_Sig) seq = ifc.RX_Data + 8'd1;
        tick();
      end
    end
    ifc.RX_Done_Sig = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
